evo_csr_arbiter: RTL and testbench
==================================

# evo_csr_arbiter

Round-robin arbiter that shares the single CSR register bus (CSR_AWIDTH address, CSR_DWIDTH data) between several requesters, such as the core bridge, the I2C register slave and the Avalon bridge. It accepts one command at a time, sequences the CSR read or write strobe, waits a fixed read latency, and returns a completion pulse to the winning requester. It sits between the requesters and the CSR decode fabric of the port, D2F and EIC register blocks.

## Interface
Parameters:
- NUM_REQ, 3 — number of requesters, legal 2..8
- AWIDTH, CSR_AWIDTH (12) — CSR address width
- DWIDTH, CSR_DWIDTH (32) — CSR data width
- RD_LATENCY, 1 — cycles from the csr_rd strobe to valid csr_rdata, legal 1..4; any other value is an elaboration error

Ports:
- clk  in  1  — single clock; all state on rising edge
- rstn  in  1  — reset, asynchronous, active-low
- req_valid  in  NUM_REQ  — per-requester command valid
- req_we  in  NUM_REQ  — 1 = write, 0 = read
- req_addr  in  NUM_REQ*AWIDTH  — requester i at [i*AWIDTH +: AWIDTH]
- req_wdata  in  NUM_REQ*DWIDTH  — requester i at [i*DWIDTH +: DWIDTH]
- req_ready  out  NUM_REQ  — one-hot command accept, combinational
- rsp_valid  out  NUM_REQ  — one-hot completion pulse, registered
- rsp_rdata  out  DWIDTH  — read data; valid while rsp_valid is high for a read
- csr_rd  out  1  — one-cycle read strobe
- csr_wr  out  1  — one-cycle write strobe
- csr_addr  out  AWIDTH  — registered command address
- csr_wdata  out  DWIDTH  — registered command write data
- csr_rdata  in  DWIDTH  — target read data
- busy  out  1  — high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid bit is set, pick winner w by round-robin, searching from last+1 and wrapping modulo NUM_REQ. Assert req_ready[w] in the same cycle. Capture we/addr/wdata/w and set last = w. Next state is ISSUE. With no requests, stay in IDLE.
- ISSUE: drive csr_wr (write) or csr_rd (read) high for exactly one cycle. Write → RESP. Read → WAIT, with the counter loaded to RD_LATENCY-1. Counter width is $clog2(RD_LATENCY+1).
- WAIT: decrement the counter. When it reaches 0, load the rdata register from csr_rdata → RESP. For RD_LATENCY=1, WAIT lasts one cycle.
- RESP: rsp_valid[w]=1 for one cycle → IDLE. For a read, rsp_rdata holds the captured data. rsp_rdata keeps its value until the next read capture.
- Handshake rules:
  - A requester holds valid, we, addr and wdata stable until it sees req_ready high.
  - It deasserts valid, or presents a new command, in the following cycle.
  - A non-granted requester may drop valid at any time without effect.
- req_ready is only ever asserted in IDLE, so at most one transaction is in flight.
- csr_addr and csr_wdata hold the last command between transactions. They matter only while a strobe is high.

## Timing
- Grant in cycle T (IDLE): strobe at T+1.
  - Write: rsp_valid at T+2; next grant no earlier than T+3.
  - Read: csr_rdata sampled at the end of cycle T+RD_LATENCY+1; rsp_valid and rsp_rdata at T+RD_LATENCY+2.
- Throughput is 1 write per 3 cycles, or 1 read per RD_LATENCY+3 cycles.
- Reset values (rstn low):
  - req_ready, rsp_valid, csr_rd, csr_wr, busy = 0.
  - csr_addr, csr_wdata, rsp_rdata = 0.
  - State IDLE; last = NUM_REQ-1, so requester 0 has first priority.
- Reset asserted mid-transaction: all outputs go to reset values immediately (asynchronous). The in-flight command is dropped; no rsp_valid and no further strobe.
- Wrap-around: last = NUM_REQ-1 searches from 0.
- Simultaneous requests: exactly one req_ready bit is set. A continuously requesting requester is granted at least once every NUM_REQ transactions.

## Test plan
- Reset: hold rstn low with all req_valid=1 → every output is 0 and busy=0; after release, req_ready=3'b001 in the first IDLE cycle.
- Single write: req 1, addr 0x00E, wdata 0xA5A50001 at T → req_ready[1] at T; csr_wr=1, csr_addr=0x00E, csr_wdata=0xA5A50001 at T+1; rsp_valid=3'b010 at T+2; busy=0 at T+3.
- Single read, RD_LATENCY=2: req 2, addr 0x00F; target drives 0x0000000F at T+3 → csr_rd at T+1 only; rsp_valid=3'b100 with rsp_rdata=0x0000000F at T+4.
- Fairness: all three requesters issue back-to-back writes → grant order 0,1,2,0,1,2; no requester waits more than 3 transactions.
- Wrap-around: last grant = 2, then req 0 and req 2 both valid → req 0 granted; next grant goes to req 2.
- Reset during WAIT (RD_LATENCY=4): pulse rstn low during the second WAIT cycle → no rsp_valid, csr_rd=0, busy=0; after release, req 0 has priority.

Source files
------------

// File: rtl/evo_csr_arbiter.sv
// Round-robin arbiter sharing one CSR register bus between NUM_REQ requesters.
// One command in flight at a time: grant, strobe, optional read wait, completion pulse.
module evo_csr_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int AWIDTH     = 12,
  parameter int DWIDTH     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*AWIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DWIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DWIDTH-1:0]         rsp_rdata,
  output logic                      csr_rd,
  output logic                      csr_wr,
  output logic [AWIDTH-1:0]         csr_addr,
  output logic [DWIDTH-1:0]         csr_wdata,
  input  logic [DWIDTH-1:0]         csr_rdata,
  output logic                      busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(RD_LATENCY + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_param
    $error("evo_csr_arbiter: NUM_REQ must be 2..8 and RD_LATENCY must be 1..4");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  state_t          state_next;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win;
  logic [IW-1:0]   win_q;
  logic            found;
  logic            we_q;
  logic [CW-1:0]   cnt;

  // Search starts just after the previous winner and wraps, so priority rotates.
  always_comb begin
    int            idx;
    logic [IW-1:0] pos;
    found = 1'b0;
    win   = last;
    idx   = 0;
    pos   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      pos = IW'(idx);
      if (!found && req_valid[pos]) begin
        found = 1'b1;
        win   = pos;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    rsp_valid  = '0;
    csr_wr     = 1'b0;
    csr_rd     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        // Gated by rstn so no grant leaks out combinationally while held in reset.
        if (found && rstn) req_ready[win] = 1'b1;
        if (found) state_next = ISSUE;
      end
      ISSUE: begin
        csr_wr     = we_q;
        csr_rd     = !we_q;
        state_next = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_next = RESP;
      end
      RESP: begin
        rsp_valid[win_q] = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last      <= IW'(NUM_REQ - 1);
      win_q     <= '0;
      we_q      <= 1'b0;
      csr_addr  <= '0;
      csr_wdata <= '0;
      cnt       <= '0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            last      <= win;
            win_q     <= win;
            we_q      <= req_we[win];
            csr_addr  <= req_addr[int'(win)*AWIDTH +: AWIDTH];
            csr_wdata <= req_wdata[int'(win)*DWIDTH +: DWIDTH];
          end
        end
        ISSUE: cnt <= CW'(RD_LATENCY - 1);
        WAIT: begin
          if (cnt == '0) rsp_rdata <= csr_rdata;
          else           cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_evo_csr_arbiter.sv
// Directed bench for evo_csr_arbiter: a RD_LATENCY=2 instance driven by a cycle table,
// plus a RD_LATENCY=4 instance for reset-during-wait and long-latency reads.
module tb_evo_csr_arbiter;

  localparam int N  = 3;
  localparam int AW = 12;
  localparam int DW = 32;

  logic              clk;
  logic              rstn;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_we;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [DW-1:0]     csr_rdata;

  logic [N-1:0]      ready2, rsp2, ready4, rsp4;
  logic [DW-1:0]     rdata2, rdata4, wdata2, wdata4;
  logic [AW-1:0]     addr2, addr4;
  logic              rd2, wr2, busy2, rd4, wr4, busy4;

  int tests;
  int failures;

  evo_csr_arbiter #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW), .RD_LATENCY(2)) dut2 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready2),
    .rsp_valid(rsp2), .rsp_rdata(rdata2), .csr_rd(rd2), .csr_wr(wr2),
    .csr_addr(addr2), .csr_wdata(wdata2), .csr_rdata(csr_rdata), .busy(busy2)
  );

  evo_csr_arbiter #(.NUM_REQ(N), .AWIDTH(AW), .DWIDTH(DW), .RD_LATENCY(4)) dut4 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready4),
    .rsp_valid(rsp4), .rsp_rdata(rdata4), .csr_rd(rd4), .csr_wr(wr4),
    .csr_addr(addr4), .csr_wdata(wdata4), .csr_rdata(csr_rdata), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  we;
    logic [31:0] rdata;
    logic [2:0]  ready;
    logic [2:0]  rsp;
    logic        rd;
    logic        wr;
    logic        busy;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] valid, input logic [2:0] we, input logic [31:0] rdata,
                              input logic [2:0] ready, input logic [2:0] rsp, input logic rd,
                              input logic wr, input logic busy, input logic [11:0] addr,
                              input logic [31:0] wdata, input logic chk, input logic [31:0] erd);
    vec_t v;
    v.valid = valid; v.we = we; v.rdata = rdata; v.ready = ready; v.rsp = rsp;
    v.rd = rd; v.wr = wr; v.busy = busy; v.addr = addr; v.wdata = wdata;
    v.chk_rdata = chk; v.exp_rdata = erd;
    return v;
  endfunction

  task automatic apply_stimulus(input logic [2:0] valid, input logic [2:0] we, input logic [31:0] rdata);
    req_valid = valid;
    req_we    = we;
    csr_rdata = rdata;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    rstn      = 1'b0;
    req_addr  = {12'h00F, 12'h00E, 12'h00D};
    req_wdata = {32'h22220002, 32'hA5A50001, 32'h11110000};
    apply_stimulus(3'b111, 3'b111, 32'h0);

    // Fairness: three back-to-back write streams, two full rotations.
    for (int r = 0; r < 2; r++) begin
      vecs.push_back(mk(7, 7, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(7, 7, 0, 0, 0, 0, 1, 1, 12'h00D, 32'h11110000, 0, 0));
      vecs.push_back(mk(7, 7, 0, 0, 3'b001, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(7, 7, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(7, 7, 0, 0, 0, 0, 1, 1, 12'h00E, 32'hA5A50001, 0, 0));
      vecs.push_back(mk(7, 7, 0, 0, 3'b010, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(7, 7, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(7, 7, 0, 0, 0, 0, 1, 1, 12'h00F, 32'h22220002, 0, 0));
      vecs.push_back(mk(7, 7, 0, 0, 3'b100, 0, 0, 1, 0, 0, 0, 0));
    end
    // Wrap-around: last=2, requesters 0 and 2 contend.
    vecs.push_back(mk(5, 5, 0, 3'b001, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(5, 5, 0, 0, 0, 0, 1, 1, 12'h00D, 32'h11110000, 0, 0));
    vecs.push_back(mk(5, 5, 0, 0, 3'b001, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(5, 5, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 12'h00F, 32'h22220002, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3'b100, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Single write from requester 1.
    vecs.push_back(mk(2, 2, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 12'h00E, 32'hA5A50001, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3'b010, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Single read from requester 2; data only valid at T+3.
    vecs.push_back(mk(4, 0, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 12'h00F, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'hBAD0BAD0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0000000F, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h33333333, 0, 3'b100, 0, 0, 1, 0, 0, 1, 32'h0000000F));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0000000F));
    // Second read from requester 0 replaces the held read data.
    vecs.push_back(mk(1, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0, 1, 32'h0000000F));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 12'h00D, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'h12345678, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 32'hCAFEF00D, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 3'b001, 0, 0, 1, 0, 0, 1, 32'hCAFEF00D));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D));

    // Reset held with every requester asking: all outputs quiet.
    repeat (2) @(negedge clk);
    #1;
    check_output("reset ready", 32'(ready2), 0);
    check_output("reset rsp_valid", 32'(rsp2), 0);
    check_output("reset csr_rd", 32'(rd2), 0);
    check_output("reset csr_wr", 32'(wr2), 0);
    check_output("reset busy", 32'(busy2), 0);
    check_output("reset csr_addr", 32'(addr2), 0);
    check_output("reset csr_wdata", wdata2, 0);
    check_output("reset rsp_rdata", rdata2, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (i == 0) rstn = 1'b1;
      apply_stimulus(vecs[i].valid, vecs[i].we, vecs[i].rdata);
      #1;
      check_output($sformatf("row%0d ready", i), 32'(ready2), 32'(vecs[i].ready));
      check_output($sformatf("row%0d rsp_valid", i), 32'(rsp2), 32'(vecs[i].rsp));
      check_output($sformatf("row%0d csr_rd", i), 32'(rd2), 32'(vecs[i].rd));
      check_output($sformatf("row%0d csr_wr", i), 32'(wr2), 32'(vecs[i].wr));
      check_output($sformatf("row%0d busy", i), 32'(busy2), 32'(vecs[i].busy));
      if (vecs[i].rd || vecs[i].wr)
        check_output($sformatf("row%0d csr_addr", i), 32'(addr2), 32'(vecs[i].addr));
      if (vecs[i].wr)
        check_output($sformatf("row%0d csr_wdata", i), wdata2, vecs[i].wdata);
      if (vecs[i].chk_rdata)
        check_output($sformatf("row%0d rsp_rdata", i), rdata2, vecs[i].exp_rdata);
    end

    // Long-latency instance: reset pulse during the second WAIT cycle.
    @(negedge clk);
    rstn = 1'b0;
    apply_stimulus(3'b000, 3'b000, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    apply_stimulus(3'b001, 3'b000, 32'h0);
    #1;
    check_output("rl4 grant ready", 32'(ready4), 32'h1);
    @(negedge clk);
    apply_stimulus(3'b000, 3'b000, 32'h0);
    #1;
    check_output("rl4 issue csr_rd", 32'(rd4), 32'h1);
    check_output("rl4 issue csr_addr", 32'(addr4), 32'h00D);
    @(negedge clk);
    #1;
    check_output("rl4 wait1 busy", 32'(busy4), 32'h1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_output("rl4 midreset rsp_valid", 32'(rsp4), 0);
    check_output("rl4 midreset csr_rd", 32'(rd4), 0);
    check_output("rl4 midreset busy", 32'(busy4), 0);
    check_output("rl4 midreset csr_addr", 32'(addr4), 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      check_output($sformatf("rl4 post%0d rsp_valid", k), 32'(rsp4), 0);
      check_output($sformatf("rl4 post%0d csr_rd", k), 32'(rd4), 0);
      check_output($sformatf("rl4 post%0d busy", k), 32'(busy4), 0);
    end

    // After reset, requester 0 wins over 2, then a full four-cycle-latency read.
    @(negedge clk);
    apply_stimulus(3'b101, 3'b000, 32'h0);
    #1;
    check_output("rl4 priority ready", 32'(ready4), 32'h1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      apply_stimulus(3'b000, 3'b000, 32'h000000A0 + 32'(k));
      #1;
      check_output($sformatf("rl4 T+%0d csr_rd", k), 32'(rd4), (k == 1) ? 32'h1 : 32'h0);
      check_output($sformatf("rl4 T+%0d rsp_valid", k), 32'(rsp4), (k == 6) ? 32'h1 : 32'h0);
    end
    check_output("rl4 rsp_rdata", rdata4, 32'h000000A5);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
